pipe_ctrl_unit: RTL

Parametrised, pipelined control unit for the 5-stage RISC core. It decodes the ID-stage opcode into a control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB registers, so each stage sees its own signals. It adds load-use hazard detection, bubble insertion, flush handling and external freeze. It drives the IM/PC enable and sits between the IF/ID register and the datapath stages.

---
 rtl/ctrl_pkg.sv | 28 ++
 rtl/ctrl_decode.sv | 50 +++++
 rtl/pipe_ctrl_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode/ALUOp encodings and the per-stage control bundle shared by the pipeline control unit.
package ctrl_pkg;

  localparam logic [3:0] OP_SW   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SUBI = 4'b0111;
  localparam logic [3:0] OP_NAND = 4'b1111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_OR   = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_NAND = 2'b11;

  typedef struct packed {
    logic       alusrc;
    logic [1:0] aluop;
    logic       mr;
    logic       mw;
    logic       mreg;
    logic       enrw;
    logic       valid;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational ID-stage decode of opcode into a control bundle plus rt-read and legality flags.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                id_valid,
  output ctrl_bundle_t        bundle,
  output logic                uses_rt,
  output logic                is_legal
);

  ctrl_bundle_t dec;

  always_comb begin
    dec      = BUBBLE;
    uses_rt  = 1'b0;
    is_legal = 1'b1;
    case (opcode)
      OPCODE_W'(OP_SW): begin
        dec.alusrc = 1'b1; dec.aluop = ALU_ADD; dec.mw = 1'b1; dec.valid = 1'b1;
        uses_rt    = 1'b1;
      end
      OPCODE_W'(OP_ADD): begin
        dec.aluop = ALU_ADD; dec.enrw = 1'b1; dec.valid = 1'b1;
        uses_rt   = 1'b1;
      end
      OPCODE_W'(OP_LW): begin
        dec.alusrc = 1'b1; dec.aluop = ALU_ADD; dec.mr = 1'b1;
        dec.mreg   = 1'b1; dec.enrw = 1'b1; dec.valid = 1'b1;
      end
      OPCODE_W'(OP_OR): begin
        dec.aluop = ALU_OR; dec.enrw = 1'b1; dec.valid = 1'b1;
        uses_rt   = 1'b1;
      end
      OPCODE_W'(OP_SUBI): begin
        dec.alusrc = 1'b1; dec.aluop = ALU_SUB; dec.enrw = 1'b1; dec.valid = 1'b1;
      end
      OPCODE_W'(OP_NAND): begin
        dec.aluop = ALU_NAND; dec.enrw = 1'b1; dec.valid = 1'b1;
        uses_rt   = 1'b1;
      end
      default: is_legal = 1'b0;
    endcase
  end

  assign bundle = id_valid ? dec : BUBBLE;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - ID/EX, EX/MEM, MEM/WB control registers with load-use stall, flush and freeze.
// CTRL_ILLEGAL_TRAP_EN adds the sticky illegal flag and saturating illegal_cnt (and the CNT_W parameter).
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int REG_W    = 3,
  parameter int ALUOP_W  = 2
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  parameter int CNT_W    = 8
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                ST,
  input  logic                flush,
  output logic                ex_alusrc,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic                mem_mr,
  output logic                mem_mw,
  output logic                wb_mreg,
  output logic                wb_enrw,
  output logic [REG_W-1:0]    wb_rd,
  output logic                en_im,
  output logic                hazard_stall
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                illegal,
  output logic [CNT_W-1:0]    illegal_cnt
`endif
);

  ctrl_bundle_t     dec, id_next, ex_q, mem_q, wb_q;
  logic [REG_W-1:0] id_next_rd, ex_rd, mem_rd, wb_rd_q;
  logic             uses_rt, is_legal, reads_regs, load_use, advance;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode   (opcode),
    .id_valid (id_valid),
    .bundle   (dec),
    .uses_rt  (uses_rt),
    .is_legal (is_legal)
  );

  // Every legal instruction reads rs; only the R-type ops and SW also read rt.
  assign reads_regs = id_valid && is_legal;
  assign load_use   = ex_q.valid && ex_q.mr && (ex_rd != '0) && reads_regs &&
                      ((ex_rd == id_rs) || (uses_rt && (ex_rd == id_rt)));

  always_comb begin
    en_im        = 1'b1;
    hazard_stall = 1'b0;
    advance      = 1'b1;
    id_next      = dec;
    id_next_rd   = dec.valid ? id_rd : '0;
    if (ST) begin
      en_im   = 1'b0;
      advance = 1'b0;
    end else if (flush) begin
      id_next    = BUBBLE;
      id_next_rd = '0;
    end else if (load_use) begin
      en_im        = 1'b0;
      hazard_stall = 1'b1;
      id_next      = BUBBLE;
      id_next_rd   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_q    <= BUBBLE;
      ex_rd   <= '0;
      mem_rd  <= '0;
      wb_rd_q <= '0;
    end else if (advance) begin
      ex_q    <= id_next;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      ex_rd   <= id_next_rd;
      mem_rd  <= ex_rd;
      wb_rd_q <= mem_rd;
    end
  end

  assign ex_alusrc = ex_q.alusrc;
  assign ex_aluop  = ALUOP_W'(ex_q.aluop);
  assign mem_mr    = mem_q.mr;
  assign mem_mw    = mem_q.mw;
  assign wb_mreg   = wb_q.mreg;
  assign wb_enrw   = wb_q.enrw;
  assign wb_rd     = wb_rd_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic trap;
  assign trap = id_valid && !is_legal && !flush && !ST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else if (trap) begin
      illegal <= 1'b1;
      if (illegal_cnt != '1) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end
`endif

endmodule
